// File: rtl/fir_mac_sched.sv
// Round-robin scheduler sharing one MAC datapath between left/right FIR jobs.
// Optional FIR_SCHED_PIPE_EN adds a DRAIN state for a synchronous-read coefficient ROM.
module fir_mac_sched #(
  parameter int unsigned NUM_TAPS = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_lft,
  input  logic              req_rght,
  output logic [ADDR_W-1:0] addr,
  output logic              ch_sel,
  output logic              clr_acc,
  output logic              acc_en,
  output logic              vld_lft,
  output logic              vld_rght,
  output logic              busy,
  output logic              ovr_err
);

`ifdef FIR_SCHED_PIPE_EN
  typedef enum logic [4:0] {
    StIdle  = 5'b00001,
    StClr   = 5'b00010,
    StMac   = 5'b00100,
    StDone  = 5'b01000,
    StDrain = 5'b10000
  } state_e;
`else
  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StClr  = 4'b0010,
    StMac  = 4'b0100,
    StDone = 4'b1000
  } state_e;
`endif

  localparam logic [ADDR_W-1:0] LastTap = ADDR_W'(NUM_TAPS - 1);

  state_e state;
  logic   pend_l, pend_r;
  logic   last_grant;  // 1 = right was served last
  logic   grant_l, grant_r;

  always_comb begin
    grant_r = (state == StIdle) && pend_r && (!pend_l || !last_grant);
    grant_l = (state == StIdle) && pend_l && !grant_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      pend_l     <= 1'b0;
      pend_r     <= 1'b0;
      last_grant <= 1'b1;
      addr       <= '0;
      ch_sel     <= 1'b0;
      clr_acc    <= 1'b0;
      acc_en     <= 1'b0;
      vld_lft    <= 1'b0;
      vld_rght   <= 1'b0;
      busy       <= 1'b0;
      ovr_err    <= 1'b0;
    end else begin
      // A req coinciding with its grant re-arms the flag, keeping the new job.
      pend_l <= req_lft | (pend_l & ~grant_l);
      pend_r <= req_rght | (pend_r & ~grant_r);
      if ((req_lft & pend_l & ~grant_l) | (req_rght & pend_r & ~grant_r)) ovr_err <= 1'b1;

      clr_acc  <= 1'b0;
      vld_lft  <= 1'b0;
      vld_rght <= 1'b0;
`ifdef FIR_SCHED_PIPE_EN
      acc_en   <= (state == StMac);
`endif

      case (state)
        StIdle: begin
          if (grant_l || grant_r) begin
            state      <= StClr;
            ch_sel     <= grant_r;
            last_grant <= grant_r;
            clr_acc    <= 1'b1;
            busy       <= 1'b1;
          end
        end
        StClr: begin
          state <= StMac;
          addr  <= '0;
`ifndef FIR_SCHED_PIPE_EN
          acc_en <= 1'b1;
`endif
        end
        StMac: begin
          if (addr == LastTap) begin
            addr <= '0;
`ifdef FIR_SCHED_PIPE_EN
            state <= StDrain;
`else
            state    <= StDone;
            acc_en   <= 1'b0;
            vld_lft  <= ~ch_sel;
            vld_rght <= ch_sel;
`endif
          end else begin
            addr <= addr + 1'b1;
          end
        end
`ifdef FIR_SCHED_PIPE_EN
        StDrain: begin
          state    <= StDone;
          vld_lft  <= ~ch_sel;
          vld_rght <= ch_sel;
        end
`endif
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          addr  <= '0;
`ifndef FIR_SCHED_PIPE_EN
          acc_en <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Randomized bench for fir_mac_sched against a job-timeline reference model.
module tb_fir_mac_sched;
  localparam int unsigned N  = 4;
  localparam int unsigned AW = 3;
`ifdef FIR_SCHED_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  // Busy cycles per job: CLR, N taps, optional DRAIN, DONE.
  localparam int L = N + 2 + PIPE;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_lft = 1'b0;
  logic          req_rght = 1'b0;
  logic [AW-1:0] addr;
  logic          ch_sel, clr_acc, acc_en, vld_lft, vld_rght, busy, ovr_err;

  always #5 clk = ~clk;

  fir_mac_sched #(.NUM_TAPS(N), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_lft (req_lft),
    .req_rght(req_rght),
    .addr    (addr),
    .ch_sel  (ch_sel),
    .clr_acc (clr_acc),
    .acc_en  (acc_en),
    .vld_lft (vld_lft),
    .vld_rght(vld_rght),
    .busy    (busy),
    .ovr_err (ovr_err)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Model: pending flags, last grant, and the running job as (channel, cycles since CLR).
  bit m_pl, m_pr, m_last, m_act, m_ch, m_ovr;
  int m_k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_pl = 0; m_pr = 0; m_last = 1; m_act = 0; m_ch = 0; m_ovr = 0; m_k = 0;
  endtask

  task automatic model_step(input bit l, input bit r);
    bit gl, gr;
    gr = !m_act && m_pr && (!m_pl || !m_last);
    gl = !m_act && m_pl && !gr;
    if (m_act) begin
      m_k++;
      if (m_k == L) m_act = 0;
    end
    if (gl || gr) begin
      m_act = 1; m_k = 0; m_ch = gr; m_last = gr;
    end
    if ((l && m_pl && !gl) || (r && m_pr && !gr)) m_ovr = 1;
    m_pl = l || (m_pl && !gl);
    m_pr = r || (m_pr && !gr);
  endtask

  task automatic compare_all();
    int e_addr;
    e_addr = (m_act && m_k >= 1 && m_k <= N) ? m_k - 1 : 0;
    check("busy",     32'(busy),     32'(m_act));
    check("clr_acc",  32'(clr_acc),  32'(m_act && m_k == 0));
    check("addr",     32'(addr),     32'(e_addr));
    check("acc_en",   32'(acc_en),   32'(m_act && m_k >= 1 + PIPE && m_k <= N + PIPE));
    check("vld_lft",  32'(vld_lft),  32'(m_act && m_k == L - 1 && !m_ch));
    check("vld_rght", 32'(vld_rght), 32'(m_act && m_k == L - 1 && m_ch));
    check("ch_sel",   32'(ch_sel),   32'(m_ch));
    check("ovr_err",  32'(ovr_err),  32'(m_ovr));
  endtask

  task automatic cycle(input bit l, input bit r);
    @(negedge clk);
    compare_all();
    req_lft  = l;
    req_rght = r;
    @(posedge clk);
    #1;
    model_step(l, r);
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(busy),     32'd0);
    check({tag, "_addr"},  32'(addr),     32'd0);
    check({tag, "_clr"},   32'(clr_acc),  32'd0);
    check({tag, "_acc"},   32'(acc_en),   32'd0);
    check({tag, "_vldl"},  32'(vld_lft),  32'd0);
    check({tag, "_vldr"},  32'(vld_rght), 32'd0);
    check({tag, "_chsel"}, 32'(ch_sel),   32'd0);
    check({tag, "_ovr"},   32'(ovr_err),  32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    req_lft  = 1'b0;
    req_rght = 1'b0;
    rst      = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    model_step(1'b0, 1'b0);
  endtask

  task automatic mid_job_reset();
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_act && m_k == 3) found = 1;  // addr == 2 in MAC
      else cycle(($urandom_range(9, 0) == 0), ($urandom_range(9, 0) == 0));
    end
    check("find_mac_addr2", 32'(found), 32'd1);
    @(negedge clk);
    compare_all();
    #2;
    req_lft  = 1'($urandom);
    req_rght = 1'($urandom);
    rst      = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    release_rst();
  endtask

  initial begin
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    release_rst();

    // Simultaneous requests: service must alternate L,R,L,R.
    repeat (6) begin
      cycle(1'b1, 1'b1);
      repeat (19) cycle(1'b0, 1'b0);
    end

    // Sparse random traffic.
    repeat (600) cycle(($urandom_range(29, 0) == 0), ($urandom_range(29, 0) == 0));

    mid_job_reset();
    cycle(1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0);

    // Two left requests during one right job: second one overruns.
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0);

    // Clear the sticky flag, then dense random traffic.
    mid_job_reset();
    repeat (400) cycle(($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
